// File: rtl/mem_if_pkg.sv
// Shared types for the line memory port.
// Line/address widths and responder FSM states.
package mem_if_pkg;

    localparam int LINE_W     = 128;
    localparam int MEM_ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/line_mem_responder_if.sv
// Line memory request/response bus.
// master = requester (cache), slave = memory.
interface line_mem_responder_if;

    import mem_if_pkg::*;

    logic                  mem_read;
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]     mem_wdata;
    logic [LINE_W-1:0]     mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/line_ram.sv
// Single-port line array with write enable and registered read.
// Array contents are not reset; only the read register is.
module line_ram
    import mem_if_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);

    logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [LINE_W-1:0] rdata_q;
    logic [LINE_W-1:0] rdata_d;

    // Read register only updates on a read strobe, otherwise holds.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    // Read data register, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Array write port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency main-memory responder for 128-bit line accesses.
// FSM IDLE -> BUSY (LATENCY cycles) -> DONE (ready pulse) -> IDLE.
module line_mem_responder
    import mem_if_pkg::*;
#(
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    line_mem_responder_if.slave  bus,
    output logic                 busy,
    output logic                 err
);

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    mem_state_t            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  is_wr_q, is_wr_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]     wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  ram_we;
    logic                  ram_re;

    // Next-state logic: accept in IDLE, count down in BUSY, pulse in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        err_d   = err_q;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    is_wr_d = bus.mem_write;
                    addr_d  = bus.mem_addr[DEPTH_LOG2-1:0];
                    wdata_d = bus.mem_wdata;
                    cnt_d   = LAT_M1;
                    state_d = BUSY;
                    if (bus.mem_read && bus.mem_write) begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    ram_we  = is_wr_q;
                    ram_re  = !is_wr_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and request latches; reset aborts any access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    line_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .re      (ram_re),
        .addr    (addr_q),
        .wdata   (wdata_q),
        .rdata   (bus.mem_rdata)
    );

    // Upper address bits alias and are intentionally dropped.
    generate
        if (DEPTH_LOG2 < MEM_ADDR_W) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.mem_addr[MEM_ADDR_W-1:DEPTH_LOG2];
        end
    endgenerate

    assign bus.mem_ready = ready_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized self-checking bench for line_mem_responder.
// Two instances: LATENCY=8 and LATENCY=1, both DEPTH_LOG2=10.
module tb_line_mem_responder;

    logic clk;
    logic reset_n;
    logic busy8, err8, busy1, err1;

    int n_chk  = 0;
    int n_fail = 0;

    line_mem_responder_if bus8 ();
    line_mem_responder_if bus1 ();

    line_mem_responder #(.LATENCY(8), .DEPTH_LOG2(10)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8),
        .busy    (busy8),
        .err     (err8)
    );

    line_mem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1),
        .busy    (busy1),
        .err     (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-instance line store, last read line, sticky error.
    logic [127:0] mdl8 [int];
    logic [127:0] mdl1 [int];
    logic [127:0] last8, last1;
    logic         errm8, errm1;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus1.mem_ready : bus8.mem_ready;
    endfunction

    function automatic logic bsy(input bit sel);
        return sel ? busy1 : busy8;
    endfunction

    function automatic logic erro(input bit sel);
        return sel ? err1 : err8;
    endfunction

    function automatic logic [127:0] rdat(input bit sel);
        return sel ? bus1.mem_rdata : bus8.mem_rdata;
    endfunction

    function automatic bit known(input bit sel, input int line);
        return sel ? mdl1.exists(line) : mdl8.exists(line);
    endfunction

    task automatic drive(input bit sel, input bit rd, input bit wr,
                         input logic [27:0] a, input logic [127:0] wd);
        if (sel) begin
            bus1.mem_read = rd; bus1.mem_write = wr;
            bus1.mem_addr = a;  bus1.mem_wdata = wd;
        end else begin
            bus8.mem_read = rd; bus8.mem_write = wr;
            bus8.mem_addr = a;  bus8.mem_wdata = wd;
        end
    endtask

    // One full transaction; called just after a rising edge (start of cycle 0).
    task automatic txn(input bit sel, input bit rd, input bit wr,
                       input logic [27:0] a, input logic [127:0] wd);
        int lat;
        int line;
        int cyc;
        int rc;
        logic [127:0] exp_rd;
        logic exp_err;
        lat  = sel ? 1 : 8;
        line = int'(a) % 1024;
        rc   = -1;
        if (wr) begin
            if (sel) mdl1[line] = wd; else mdl8[line] = wd;
            exp_rd = sel ? last1 : last8;
        end else begin
            exp_rd = sel ? mdl1[line] : mdl8[line];
            if (sel) last1 = exp_rd; else last8 = exp_rd;
        end
        if (rd && wr) begin
            if (sel) errm1 = 1'b1; else errm8 = 1'b1;
        end
        exp_err = sel ? errm1 : errm8;
        drive(sel, rd, wr, a, wd);
        cyc = 0;
        while (cyc <= lat + 4) begin
            @(negedge clk);
            if (cyc == 0) check("busy_idle", 128'(bsy(sel)), 128'd0);
            else check("busy_active", 128'(bsy(sel)), 128'd1);
            if (rdy(sel)) begin
                rc = cyc;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("ready_cycle", 128'(rc), 128'(lat + 1));
        check("rdata", rdat(sel), exp_rd);
        check("err", 128'(erro(sel)), 128'(exp_err));
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : main
        logic [127:0] pat;
        bit sel, rd, wr;
        logic [27:0] a;
        bit saw_ready;
        errm8 = 1'b0; errm1 = 1'b0;
        last8 = '0;   last1 = '0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b0;
        #2;
        check("rst_ready8", 128'(bus8.mem_ready), 128'd0);
        check("rst_rdata8", bus8.mem_rdata, 128'd0);
        check("rst_busy8", 128'(busy8), 128'd0);
        check("rst_err8", 128'(err8), 128'd0);
        check("rst_rdata1", bus1.mem_rdata, 128'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload and read back at 0x10.
        pat = {4{32'hDEADBEEF}};
        txn(1'b0, 1'b0, 1'b1, 28'h0000010, pat);
        txn(1'b0, 1'b1, 1'b0, 28'h0000010, '0);

        // Back-to-back write then read of the same line.
        pat = 128'h0123456789ABCDEF0123456789ABCDEF;
        txn(1'b0, 1'b0, 1'b1, 28'h5, pat);
        txn(1'b0, 1'b1, 1'b0, 28'h5, '0);

        // Aliasing: 0x405 and 0x005 are the same line.
        txn(1'b0, 1'b0, 1'b1, 28'h405, {16{8'hA5}});
        txn(1'b0, 1'b1, 1'b0, 28'h005, '0);

        // Simultaneous read+write acts as a write and sets sticky err.
        txn(1'b0, 1'b1, 1'b1, 28'h3, {16{8'h77}});
        txn(1'b0, 1'b1, 1'b0, 28'h3, '0);

        // Reset in cycle 4 of a write aborts it.
        txn(1'b0, 1'b0, 1'b1, 28'h9, {16{8'h11}});
        drive(1'b0, 1'b0, 1'b1, 28'h9, {16{8'h22}});
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        check("abort_ready", 128'(bus8.mem_ready), 128'd0);
        check("abort_busy", 128'(busy8), 128'd0);
        check("abort_err", 128'(err8), 128'd0);
        check("abort_rdata", bus8.mem_rdata, 128'd0);
        errm8 = 1'b0; errm1 = 1'b0;
        last8 = '0;   last1 = '0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        saw_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus8.mem_ready) saw_ready = 1'b1;
        end
        check("abort_no_ready", 128'(saw_ready), 128'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        txn(1'b0, 1'b1, 1'b0, 28'h9, '0);

        // LATENCY=1: back-to-back accepts at cycle 0 and cycle 3.
        txn(1'b1, 1'b0, 1'b1, 28'h20, rnd128());
        txn(1'b1, 1'b1, 1'b0, 28'h20, '0);
        txn(1'b1, 1'b1, 1'b0, 28'h20, '0);

        // Random traffic on both instances.
        for (int i = 0; i < 60; i++) begin
            sel = ($urandom_range(0, 3) == 0);
            a   = 28'($urandom);
            a   = {a[27:10], 6'd0, a[3:0]};
            rd  = $urandom_range(0, 1) == 1;
            wr  = !rd || ($urandom_range(0, 9) == 0);
            if (!wr && !known(sel, int'(a) % 1024)) wr = 1'b1;
            txn(sel, rd, wr, a, rnd128());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
